// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_pkg
//  Description : Shared FP16 datapath definitions used by the pack and unpack
//                stages: IEEE-754 binary16 field widths, exponent bias,
//                canonical special encodings and the unpack FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package fp16_pkg;

    // binary16 field widths; MANT_W includes the explicit hidden bit
    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int MANT_W = 11;

    // Exponent bias subtracted from the biased exponent field
    localparam int BIAS = 15;

    // Canonical special encodings
    localparam logic [15:0] FP16_QNAN = 16'hFE00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_NINF = 16'hFC00;

    // Unpack FSM: IDLE accepts words, NORM shifts a subnormal one bit per cycle
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        NORM = 1'b1
    } unpack_state_t;

endpackage : fp16_pkg
`default_nettype wire

// File: rtl/fp16_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_lzc
//  Description : 11-bit leading-zero counter. Returns the number of zero bits
//                above the most significant set bit; an all-zero input
//                returns 11.
//  Ports       : data_i  [10:0]  value to scan
//                count_o [3:0]   leading-zero count (0..11)
//  Revision    : 1.0  initial release
// ============================================================================
module fp16_lzc
    import fp16_pkg::*;
(
    input  logic [MANT_W-1:0] data_i,
    output logic [3:0]        count_o
);

    // Scan upward so the highest set bit is the last one to write the count
    always_comb begin
        count_o = 4'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (data_i[i]) begin
                count_o = 4'(MANT_W - 1 - i);
            end
        end
    end

endmodule : fp16_lzc
`default_nettype wire

// File: rtl/fp16_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_unpack
//  Description : FP16 decode stage. Splits a binary16 word into sign, signed
//                unbiased exponent and an 11-bit mantissa with explicit hidden
//                bit, and raises NaN / +Inf / -Inf / zero flags. Subnormals are
//                normalised so mant_out[10] is set for every finite non-zero
//                input.
//  Build option: FP16_UNPACK_FAST_NORM_EN
//                  defined   - single-cycle normalisation via fp16_lzc,
//                              in_ready follows enable, latency 1 for all.
//                  undefined - iterative one-bit-per-cycle NORM state.
//  Ports       : clk, rst_n (async active-low), enable (low = sync clear)
//                in_valid/in_data/in_ready   - input handshake
//                u_valid                     - one-cycle result strobe
//                sign_out/exp_out/mant_out   - decoded fields (held)
//                is_nan/is_pinf/is_ninf/is_zero - classification flags (held)
//  Revision    : 1.0  initial release
// ============================================================================
module fp16_unpack #(
    parameter int BIAS      = 15,
    parameter int EXP_OUT_W = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic [15:0]          in_data,
    output logic                 in_ready,
    output logic                 u_valid,
    output logic                 sign_out,
    output logic [EXP_OUT_W-1:0] exp_out,
    output logic [10:0]          mant_out,
    output logic                 is_nan,
    output logic                 is_pinf,
    output logic                 is_ninf,
    output logic                 is_zero
);

    import fp16_pkg::*;

    localparam int EW = EXP_OUT_W;

    // ------------------------------------------------------------------
    // Input field decode
    // ------------------------------------------------------------------
    logic              w_sign;
    logic [EXP_W-1:0]  w_e;
    logic [FRAC_W-1:0] w_f;
    logic              w_e_max;
    logic              w_e_zero;
    logic              w_f_zero;
    logic              w_accept;
    logic [EW-1:0]     w_exp_normal;
    logic [EW-1:0]     w_exp_sub0;

    assign w_sign       = in_data[15];
    assign w_e          = in_data[14:10];
    assign w_f          = in_data[9:0];
    assign w_e_max      = &w_e;
    assign w_e_zero     = ~|w_e;
    assign w_f_zero     = ~|w_f;
    assign w_exp_normal = EW'(int'(w_e) - BIAS);
    // A subnormal has the same scale as the smallest normal, 1-BIAS
    assign w_exp_sub0   = EW'(1 - BIAS);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    unpack_state_t     state_q, state_d;
    logic              u_valid_q, u_valid_d;
    logic              sign_q, sign_d;
    logic [EW-1:0]     exp_q, exp_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic              nan_q, nan_d;
    logic              pinf_q, pinf_d;
    logic              ninf_q, ninf_d;
    logic              zero_q, zero_d;

    // State is held at IDLE in the fast build, so this reduces to enable there
    assign in_ready = enable && rst_n && (state_q == IDLE);
    assign w_accept = in_valid && in_ready;

`ifdef FP16_UNPACK_FAST_NORM_EN
    // Single-cycle normalisation: shift out the leading zeros in one step
    logic [3:0]        w_lz;
    logic [MANT_W-1:0] w_mant_fast;
    logic [EW-1:0]     w_exp_fast;

    fp16_lzc u_lzc (
        .data_i  ({1'b0, w_f}),
        .count_o (w_lz)
    );

    assign w_mant_fast = {1'b0, w_f} << w_lz;
    assign w_exp_fast  = w_exp_sub0 - EW'(w_lz);
`else
    // Working registers for the iterative normaliser
    logic              sign_w_q, sign_w_d;
    logic [EW-1:0]     exp_w_q, exp_w_d;
    logic [MANT_W-1:0] mant_w_q, mant_w_d;
    logic [MANT_W-1:0] w_shift;
    logic [EW-1:0]     w_exp_dec;

    assign w_shift   = mant_w_q << 1;
    assign w_exp_dec = exp_w_q - EW'(1);
`endif

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        u_valid_d = 1'b0;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        nan_d     = nan_q;
        pinf_d    = pinf_q;
        ninf_d    = ninf_q;
        zero_d    = zero_q;
`ifndef FP16_UNPACK_FAST_NORM_EN
        sign_w_d  = sign_w_q;
        exp_w_d   = exp_w_q;
        mant_w_d  = mant_w_q;
`endif

        if (!enable) begin
            // Synchronous clear: same state as reset, in-flight word dropped
            state_d = IDLE;
            sign_d  = 1'b0;
            exp_d   = '0;
            mant_d  = '0;
            nan_d   = 1'b0;
            pinf_d  = 1'b0;
            ninf_d  = 1'b0;
            zero_d  = 1'b0;
`ifndef FP16_UNPACK_FAST_NORM_EN
            sign_w_d = 1'b0;
            exp_w_d  = '0;
            mant_w_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        // Flags are exclusive: clear all, then set one
                        nan_d  = 1'b0;
                        pinf_d = 1'b0;
                        ninf_d = 1'b0;
                        zero_d = 1'b0;
                        if (w_e_max) begin
                            u_valid_d = 1'b1;
                            sign_d    = w_sign;
                            exp_d     = '0;
                            mant_d    = '0;
                            nan_d     = !w_f_zero;
                            pinf_d    = w_f_zero && !w_sign;
                            ninf_d    = w_f_zero && w_sign;
                        end else if (w_e_zero && w_f_zero) begin
                            u_valid_d = 1'b1;
                            sign_d    = w_sign;
                            exp_d     = '0;
                            mant_d    = '0;
                            zero_d    = 1'b1;
                        end else if (w_e_zero) begin
`ifdef FP16_UNPACK_FAST_NORM_EN
                            u_valid_d = 1'b1;
                            sign_d    = w_sign;
                            exp_d     = w_exp_fast;
                            mant_d    = w_mant_fast;
`else
                            sign_w_d  = w_sign;
                            exp_w_d   = w_exp_sub0;
                            mant_w_d  = {1'b0, w_f};
                            state_d   = NORM;
`endif
                        end else begin
                            u_valid_d = 1'b1;
                            sign_d    = w_sign;
                            exp_d     = w_exp_normal;
                            mant_d    = {1'b1, w_f};
                        end
                    end
                end
`ifndef FP16_UNPACK_FAST_NORM_EN
                NORM: begin
                    mant_w_d = w_shift;
                    exp_w_d  = w_exp_dec;
                    // Done when the shift brings the leading one into the hidden bit
                    if (w_shift[MANT_W-1]) begin
                        u_valid_d = 1'b1;
                        sign_d    = sign_w_q;
                        exp_d     = w_exp_dec;
                        mant_d    = w_shift;
                        state_d   = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            u_valid_q <= 1'b0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            nan_q     <= 1'b0;
            pinf_q    <= 1'b0;
            ninf_q    <= 1'b0;
            zero_q    <= 1'b0;
`ifndef FP16_UNPACK_FAST_NORM_EN
            sign_w_q  <= 1'b0;
            exp_w_q   <= '0;
            mant_w_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            u_valid_q <= u_valid_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            mant_q    <= mant_d;
            nan_q     <= nan_d;
            pinf_q    <= pinf_d;
            ninf_q    <= ninf_d;
            zero_q    <= zero_d;
`ifndef FP16_UNPACK_FAST_NORM_EN
            sign_w_q  <= sign_w_d;
            exp_w_q   <= exp_w_d;
            mant_w_q  <= mant_w_d;
`endif
        end
    end

    assign u_valid  = u_valid_q;
    assign sign_out = sign_q;
    assign exp_out  = exp_q;
    assign mant_out = mant_q;
    assign is_nan   = nan_q;
    assign is_pinf  = pinf_q;
    assign is_ninf  = ninf_q;
    assign is_zero  = zero_q;

endmodule : fp16_unpack
`default_nettype wire

// File: tb/tb_fp16_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp16_unpack
//  Description : Self-checking bench for fp16_unpack (and fp16_lzc). Directed
//                vector table, back-to-back and abort sequences, then random
//                words checked against a value-level reference model.
//                Honours FP16_UNPACK_FAST_NORM_EN for expected latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp16_unpack;

    localparam int EXP_OUT_W = 7;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 in_valid = 1'b0;
    logic [15:0]          in_data = 16'h0;
    logic                 in_ready;
    logic                 u_valid;
    logic                 sign_out;
    logic [EXP_OUT_W-1:0] exp_out;
    logic [10:0]          mant_out;
    logic                 is_nan, is_pinf, is_ninf, is_zero;
    logic [10:0]          lz_in = 11'h0;
    logic [3:0]           lz_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp16_unpack #(.BIAS(15), .EXP_OUT_W(EXP_OUT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .u_valid  (u_valid),
        .sign_out (sign_out),
        .exp_out  (exp_out),
        .mant_out (mant_out),
        .is_nan   (is_nan),
        .is_pinf  (is_pinf),
        .is_ninf  (is_ninf),
        .is_zero  (is_zero)
    );

    fp16_lzc u_lzc (
        .data_i  (lz_in),
        .count_o (lz_out)
    );

    // Expected result of one word; flags = {nan, pinf, ninf, zero}
    typedef struct {
        logic [15:0] w;
        logic        s;
        int          e;
        logic [10:0] m;
        logic [3:0]  flags;
        int          lat;   // cycles of extra wait after the accept edge
    } exp_t;

    function automatic exp_t mk(logic [15:0] w, logic s, int e, logic [10:0] m,
                                logic [3:0] f, int lat);
        exp_t r;
        r.w = w; r.s = s; r.e = e; r.m = m; r.flags = f;
`ifdef FP16_UNPACK_FAST_NORM_EN
        r.lat = 0;
        if (lat < 0) r.lat = 0;
`else
        r.lat = lat;
`endif
        return r;
    endfunction

    // Reference: value = F*2^-24 for subnormals, so the leading one at bit p
    // gives exponent p-24 and mantissa F scaled up to put that one at bit 10.
    function automatic exp_t model(logic [15:0] w);
        int E;
        int F;
        int p;
        E = int'(w[14:10]);
        F = int'(w[9:0]);
        p = 0;
        if (E == 31)
            return mk(w, w[15], 0, 11'h0, (F != 0) ? 4'b1000 : (w[15] ? 4'b0010 : 4'b0100), 0);
        if (E == 0 && F == 0)
            return mk(w, w[15], 0, 11'h0, 4'b0001, 0);
        if (E == 0) begin
            for (int b = 0; b < 10; b++)
                if (F >= (1 << b)) p = b;
            return mk(w, w[15], p - 24, 11'(F * (1 << (10 - p))), 4'b0000, 10 - p);
        end
        return mk(w, w[15], E - 15, 11'(1024 + F), 4'b0000, 0);
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fields(input string tag, input exp_t ex);
        chk({tag, " sign"}, longint'(sign_out), longint'(ex.s));
        chk({tag, " exp"}, longint'($signed(exp_out)), longint'(ex.e));
        chk({tag, " mant"}, longint'(mant_out), longint'(ex.m));
        chk({tag, " flags"}, longint'({is_nan, is_pinf, is_ninf, is_zero}), longint'(ex.flags));
    endtask

    // Send one word and check latency, busy behaviour, fields and pulse width
    task automatic run_word(input string tag, input exp_t ex);
        int guard;
        int n;
        bit busy_ok;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        chk({tag, " ready"}, longint'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = ex.w;
        step();
        in_valid = 1'b0;
        in_data  = 16'h0;
        n = 0;
        busy_ok = 1'b1;
        while (!u_valid && n < 30) begin
            if (in_ready) busy_ok = 1'b0;
            step();
            n++;
        end
        chk({tag, " latency"}, longint'(n), longint'(ex.lat));
        chk({tag, " busy"}, longint'(busy_ok), 1);
        chk_fields(tag, ex);
        step();
        chk({tag, " pulse"}, longint'(u_valid), 0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " u_valid"}, longint'(u_valid), 0);
        chk({tag, " in_ready"}, longint'(in_ready), 0);
        chk_fields(tag, mk(16'h0, 1'b0, 0, 11'h0, 4'b0000, 0));
    endtask

    task automatic count_pulses(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int c = 0; c < cycles; c++) begin
            if (u_valid) hits++;
            step();
        end
        chk({tag, " no u_valid"}, longint'(hits), 0);
    endtask

    exp_t vec[$];

    initial begin
        // ---------------- reset ----------------
        #2 enable = 1'b1;
        #1;
        chk_cleared("reset");
        step();
        rst_n = 1'b1;
        step();
        chk("post-reset in_ready", longint'(in_ready), 1);

        // ---------------- directed table ----------------
        vec.push_back(mk(16'h3C00, 1'b0,   0, 11'h400, 4'b0000,  0));
        vec.push_back(mk(16'h4000, 1'b0,   1, 11'h400, 4'b0000,  0));
        vec.push_back(mk(16'hC200, 1'b1,   1, 11'h600, 4'b0000,  0));
        vec.push_back(mk(16'h7BFF, 1'b0,  15, 11'h7FF, 4'b0000,  0));
        vec.push_back(mk(16'h0400, 1'b0, -14, 11'h400, 4'b0000,  0));
        vec.push_back(mk(16'h0001, 1'b0, -24, 11'h400, 4'b0000, 10));
        vec.push_back(mk(16'h0200, 1'b0, -15, 11'h400, 4'b0000,  1));
        vec.push_back(mk(16'h0010, 1'b0, -20, 11'h400, 4'b0000,  6));
        vec.push_back(mk(16'h8003, 1'b1, -23, 11'h600, 4'b0000,  9));
        vec.push_back(mk(16'h03FF, 1'b0, -15, 11'h7FE, 4'b0000,  1));
        vec.push_back(mk(16'h7C00, 1'b0,   0, 11'h000, 4'b0100,  0));
        vec.push_back(mk(16'hFC00, 1'b1,   0, 11'h000, 4'b0010,  0));
        vec.push_back(mk(16'h7E00, 1'b0,   0, 11'h000, 4'b1000,  0));
        vec.push_back(mk(16'hFE00, 1'b1,   0, 11'h000, 4'b1000,  0));
        vec.push_back(mk(16'h8000, 1'b1,   0, 11'h000, 4'b0001,  0));
        vec.push_back(mk(16'h0000, 1'b0,   0, 11'h000, 4'b0001,  0));
        foreach (vec[i])
            run_word($sformatf("vec%0d[%h]", i, vec[i].w), vec[i]);

        // ---------------- back-to-back ----------------
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        step();
        chk("b2b0 u_valid", longint'(u_valid), 1);
        chk_fields("b2b0", mk(16'h3C00, 1'b0, 0, 11'h400, 4'b0000, 0));
        chk("b2b0 in_ready", longint'(in_ready), 1);
        in_data = 16'h4000;
        step();
        chk("b2b1 u_valid", longint'(u_valid), 1);
        chk_fields("b2b1", mk(16'h4000, 1'b0, 1, 11'h400, 4'b0000, 0));
        in_data = 16'hC200;
        step();
        chk("b2b2 u_valid", longint'(u_valid), 1);
        chk_fields("b2b2", mk(16'hC200, 1'b1, 1, 11'h600, 4'b0000, 0));
        in_valid = 1'b0;
        in_data  = 16'h0;
        step();
        chk("b2b end u_valid", longint'(u_valid), 0);

        // ---------------- enable drop mid-normalisation ----------------
        run_word("prime1", mk(16'h3C00, 1'b0, 0, 11'h400, 4'b0000, 0));
        in_valid = 1'b1;
        in_data  = 16'h0010;
        step();
        in_valid = 1'b0;
        in_data  = 16'h0;
        step();
        step();
        step();
        enable = 1'b0;
        step();
        chk_cleared("enable-drop");
        enable = 1'b1;
        #1;
        chk("enable-drop in_ready", longint'(in_ready), 1);
        count_pulses("enable-drop", 10);

        // ---------------- async reset mid-normalisation ----------------
        run_word("prime2", mk(16'hBC00, 1'b1, 0, 11'h400, 4'b0000, 0));
        in_valid = 1'b1;
        in_data  = 16'h0010;
        step();
        in_valid = 1'b0;
        in_data  = 16'h0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_cleared("async-reset");
        #2 rst_n = 1'b1;
        step();
        count_pulses("async-reset", 10);
        run_word("after-reset", mk(16'h0200, 1'b0, -15, 11'h400, 4'b0000, 1));

        // ---------------- randomised words vs model ----------------
        for (int i = 0; i < 150; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            case ($urandom_range(0, 3))
                0: w[14:10] = 5'd0;
                1: w[14:10] = 5'd31;
                default: ;
            endcase
            run_word($sformatf("rnd%0d[%h]", i, w), model(w));
        end

        // ---------------- leading-zero counter ----------------
        for (int i = 0; i < 40; i++) begin
            int v;
            int bits;
            v = (i == 0) ? 0 : int'($urandom_range(1, 2047)) >> $urandom_range(0, 10);
            bits = 0;
            while (bits < 11 && (v >> bits) != 0) bits++;
            lz_in = 11'(v);
            #1;
            chk($sformatf("lzc[%0d]", v), longint'(lz_out), longint'(11 - bits));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_fp16_unpack
`default_nettype wire

// File: doc/fp16_unpack.md
Name: fp16_unpack

Overview:
Front-end decode stage of the FP16 datapath, the inverse of the pack stage. It accepts a raw IEEE-754 binary16 word and splits it into sign, an unbiased signed exponent, and an 11-bit mantissa with the hidden bit explicit. It also raises the NaN/±Inf/zero flags. Subnormal inputs are normalised by a multi-cycle shift FSM, so the output mantissa always has bit 10 set, except for zero and specials.

Parameters:
BIAS, 15, exponent bias subtracted from the biased field.
EXP_OUT_W, 7, width of the signed unbiased exponent output.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  synchronous run enable; low = synchronous clear
in_valid  in  1  input word present
in_data  in  16  FP16 word {sign, exp[4:0], frac[9:0]}
in_ready  out  1  block can accept a word this cycle
u_valid  out  1  one-cycle pulse, outputs below valid
sign_out  out  1  sign bit
exp_out  out  EXP_OUT_W  signed unbiased exponent
mant_out  out  11  {hidden, frac}, normalised
is_nan  out  1  input was NaN
is_pinf  out  1  input was +Inf
is_ninf  out  1  input was -Inf
is_zero  out  1  input was ±0

Behaviour:
- Reset (rst_n low, async): state=IDLE, all outputs 0 except in_ready=0.
- enable low (sync): same clear as reset; aborts any in-progress normalisation; the word is dropped with no u_valid.
- in_ready = enable && state==IDLE (registered state, combinational output). Accept = in_valid && in_ready at a rising edge (E0).
- FSM states: IDLE, NORM.
- Classification at accept, with E = in_data[14:10] and F = in_data[9:0]:
  - E=31, F!=0: is_nan=1, sign passed, exp_out=0, mant_out=0.
  - E=31, F=0: is_pinf or is_ninf by sign, exp_out=0, mant_out=0.
  - E=0, F=0: is_zero=1, sign passed, exp_out=0, mant_out=0.
  - 1<=E<=30: exp_out=E-BIAS (sign-extended), mant_out={1,F}.
  - Normal/special/zero: outputs registered at E0, u_valid=1 for the cycle after E0, state stays IDLE. Back-to-back accepts every cycle are allowed.
- Subnormal (E=0, F!=0):
  - At E0: working mant={0,F}, working exp=1-BIAS (-14), state->NORM, in_ready drops.
  - Each NORM edge: mant<<=1, exp-=1.
  - On the edge where the shifted mant has bit 10 set: outputs load, u_valid pulses, state->IDLE.
  - k = leading zeros of the 11-bit {0,F}, range 1..10. u_valid is high the cycle after edge E0+k. The minimum result is exp=-24 for F=1.
- Flags and data are mutually exclusive per word. All flags are cleared on every accept and then set per the classification.
- u_valid is a single-cycle pulse. sign/exp/mant/flags hold their last value until the next load.
- No output back-pressure: the consumer must take the word on the u_valid cycle.
- Arithmetic is two's complement in EXP_OUT_W bits; no overflow is possible for FP16 (range -24..+15).

Optional Feature:
FP16_UNPACK_FAST_NORM_EN
- Defined: subnormals are normalised in one cycle using the leading-zero count (shift by k, exp=-14-k). NORM state is unused, in_ready=enable, and latency is 1 for every input.
- Undefined: the iterative one-bit-per-cycle FSM described above.

Decomposition:
- Shared package fp16_pkg holds:
  - FP16 field widths (EXP_W=5, FRAC_W=10, MANT_W=11).
  - BIAS=15.
  - Constants FP16_QNAN=16'hFE00, FP16_PINF=16'h7C00, FP16_NINF=16'hFC00.
  - Unpack state enum {IDLE, NORM}.
  - This package is also reused by pack.
- Sub-module fp16_lzc: 11-bit leading-zero counter returning 4 bits. Used only in the FAST_NORM build and in bench checkers.

Test Plan:
- 16'h3C00 -> u_valid the next cycle; sign 0, exp 0, mant 0x400, all flags 0.
- Back-to-back 16'h3C00, 16'h4000, 16'hC200 on consecutive cycles -> three consecutive u_valid pulses:
  - exp 0, mant 0x400, sign 0
  - exp 1, mant 0x400, sign 0
  - exp 1, mant 0x600, sign 1
- 16'h0001 -> in_ready low for 10 cycles, u_valid at E0+10; exp -24, mant 0x400. With FAST_NORM: latency 1.
- 16'h0200 -> k=1; exp -15, mant 0x400.
- Specials:
  - 16'h7C00 -> is_pinf
  - 16'hFC00 -> is_ninf
  - 16'h7E00 -> is_nan
  - 16'h8000 -> is_zero with sign 1
  - In each case exp=0, mant=0.
- Interrupts during normalisation of 16'h0010 (k=6):
  - Drop enable for 1 cycle after 3 NORM cycles -> no u_valid, state IDLE, outputs 0. in_ready rises once enable is high.
  - Repeat with rst_n pulsed mid-NORM -> immediate clear, no u_valid.
